// File: rtl/fsk_symbol_serializer.sv
// Byte-to-symbol serializer feeding the FSK mapper: accepts bytes on a valid/ready
// handshake, buffers one, and emits four 2-bit symbols each held for a latched period.
module fsk_symbol_serializer #(
    parameter bit         MSB_FIRST = 1'b1,
    parameter logic [1:0] IDLE_SYM  = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] sym_period,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [1:0]  sel,
    output logic        sym_strobe,
    output logic        busy,
    output logic        underrun
);

    typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [7:0]  next_q, next_d;
    logic        next_full_q, next_full_d;
    logic [7:0]  cur_q, cur_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] per_q, per_d;
    logic [1:0]  sel_q, sel_d;
    logic        strobe_q, strobe_d;
    logic        busy_q, busy_d;
    logic        underrun_q, underrun_d;
    logic        start_s;

    function automatic logic [1:0] first_sym(input logic [7:0] b);
        return MSB_FIRST ? b[7:6] : b[1:0];
    endfunction

    // cur_q always holds the not-yet-sent symbols aligned so first_sym() picks the next one
    function automatic logic [7:0] shift_out(input logic [7:0] b);
        return MSB_FIRST ? {b[5:0], 2'b00} : {2'b00, b[7:2]};
    endfunction

    // Next-state, buffer and output decode
    always_comb begin
        state_d     = state_q;
        next_d      = next_q;
        next_full_d = next_full_q;
        cur_d       = cur_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        per_d       = per_q;
        sel_d       = sel_q;
        strobe_d    = 1'b0;
        underrun_d  = 1'b0;
        start_s     = 1'b0;

        if (s_valid && !next_full_q) begin
            next_d      = s_data;
            next_full_d = 1'b1;
        end else begin
            next_d      = next_q;
        end

        case (state_q)
            ST_IDLE: begin
                sel_d = IDLE_SYM;
                if (enable && next_full_q) begin
                    start_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            ST_SEND: begin
                if (cnt_q == per_q - 16'd1) begin
                    cnt_d = 16'd0;
                    if (idx_q != 2'd3) begin
                        idx_d    = idx_q + 2'd1;
                        sel_d    = first_sym(cur_q);
                        cur_d    = shift_out(cur_q);
                        strobe_d = 1'b1;
                    end else if (enable && next_full_q) begin
                        start_s = 1'b1;
                    end else begin
                        // a buffered byte held back by enable is not an underrun
                        state_d    = ST_IDLE;
                        sel_d      = IDLE_SYM;
                        underrun_d = !next_full_q;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = IDLE_SYM;
            end
        endcase

        if (start_s) begin
            cur_d       = shift_out(next_q);
            sel_d       = first_sym(next_q);
            next_full_d = 1'b0;
            idx_d       = 2'd0;
            cnt_d       = 16'd0;
            per_d       = (sym_period == 16'd0) ? 16'd1 : sym_period;
            strobe_d    = 1'b1;
            state_d     = ST_SEND;
        end else begin
            per_d       = per_q;
        end

        busy_d = (state_d == ST_SEND);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            next_q      <= 8'd0;
            next_full_q <= 1'b0;
            cur_q       <= 8'd0;
            idx_q       <= 2'd0;
            cnt_q       <= 16'd0;
            per_q       <= 16'd0;
            sel_q       <= IDLE_SYM;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_q      <= next_d;
            next_full_q <= next_full_d;
            cur_q       <= cur_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            sel_q       <= sel_d;
            strobe_q    <= strobe_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
        end
    end

    assign s_ready    = ~next_full_q;
    assign sel        = sel_q;
    assign sym_strobe = strobe_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_fsk_symbol_serializer.sv
// Directed bench for fsk_symbol_serializer: MSB-first and LSB-first instances share stimulus;
// outputs are sampled on the falling edge against hand-computed symbol sequences.
module tb_fsk_symbol_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] sym_period;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready,   s_ready_l;
    logic [1:0]  sel,       sel_l;
    logic        sym_strobe, sym_strobe_l;
    logic        busy,      busy_l;
    logic        underrun,  underrun_l;

    int n_checks = 0;
    int n_fail   = 0;

    fsk_symbol_serializer #(.MSB_FIRST(1'b1), .IDLE_SYM(2'b00)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sym_period(sym_period),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .sel(sel),
        .sym_strobe(sym_strobe), .busy(busy), .underrun(underrun)
    );

    fsk_symbol_serializer #(.MSB_FIRST(1'b0), .IDLE_SYM(2'b00)) dut_lsb (
        .clk(clk), .rst(rst), .enable(enable), .sym_period(sym_period),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_l), .sel(sel_l),
        .sym_strobe(sym_strobe_l), .busy(busy_l), .underrun(underrun_l)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [7:0] b);
        s_data  = b;
        s_valid = 1'b1;
    endtask

    // Called on the falling edge right after a byte load; seq[1:0] is the first symbol.
    task automatic expect_stream(input logic [15:0] seq, input int n_sym, input int per,
                                 input bit use_lsb, input int rdy_lo, input int rdy_hi,
                                 input int drop_en_at, input bit exp_under);
        int k;
        logic [1:0] exp_sym;
        k = 0;
        for (int i = 0; i < n_sym; i++) begin
            exp_sym = seq[2*i +: 2];
            for (int j = 0; j < per; j++) begin
                check_eq("sel",      use_lsb ? sel_l : sel, exp_sym);
                check_eq("strobe",   use_lsb ? sym_strobe_l : sym_strobe, (j == 0) ? 1 : 0);
                check_eq("busy",     use_lsb ? busy_l : busy, 1);
                check_eq("underrun", use_lsb ? underrun_l : underrun, 0);
                check_eq("s_ready",  use_lsb ? s_ready_l : s_ready,
                         (k >= rdy_lo && k <= rdy_hi) ? 0 : 1);
                if (k == drop_en_at) enable = 1'b0;
                tick();
                s_valid = 1'b0;
                k++;
            end
        end
        check_eq("end_sel",      use_lsb ? sel_l : sel, 0);
        check_eq("end_busy",     use_lsb ? busy_l : busy, 0);
        check_eq("end_strobe",   use_lsb ? sym_strobe_l : sym_strobe, 0);
        check_eq("end_underrun", use_lsb ? underrun_l : underrun, exp_under);
    endtask

    initial begin
        logic [7:0] seq6;
        rst = 1'b1; enable = 1'b0; sym_period = 16'd4; s_data = 8'h00; s_valid = 1'b0;
        tick(); tick();
        check_eq("rst_sel", sel, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", s_ready, 1);
        check_eq("rst_strobe", sym_strobe, 0);
        check_eq("rst_underrun", underrun, 0);
        rst = 1'b0;
        tick();

        // single byte, period 4: 2,3,1,0
        enable = 1'b1;
        offer(8'hB4); tick();
        check_eq("t1_ready_buffered", s_ready, 0);
        check_eq("t1_busy_pre", busy, 0);
        s_valid = 1'b0; tick();
        expect_stream(16'h001E, 4, 4, 1'b0, -1, -1, -1, 1'b1);
        tick();
        check_eq("t1_underrun_pulse", underrun, 0);

        // back-to-back, period 3: 2,3,1,0,0,1,2,3
        sym_period = 16'd3;
        offer(8'hB4); tick();
        offer(8'h1B); tick();
        expect_stream(16'hE41E, 8, 3, 1'b0, 1, 11, -1, 1'b1);
        tick();

        // minimum period 0 then 1: 3,2,1,0 on consecutive cycles
        for (int p = 0; p < 2; p++) begin
            sym_period = 16'(p);
            offer(8'hE4); tick();
            s_valid = 1'b0; tick();
            expect_stream(16'h001B, 4, 1, 1'b0, -1, -1, -1, 1'b1);
            tick();
        end

        // LSB-first instance, period 2: 0,1,3,2
        sym_period = 16'd2;
        offer(8'hB4); tick();
        s_valid = 1'b0; tick();
        expect_stream(16'h00B4, 4, 2, 1'b1, -1, -1, -1, 1'b1);
        tick();

        // enable drop in 2nd symbol: B4 completes, no underrun, 1B held until enable returns
        sym_period = 16'd4;
        offer(8'hB4); tick();
        offer(8'h1B); tick();
        expect_stream(16'h001E, 4, 4, 1'b0, 1, 15, 5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_ready", s_ready, 0);
            check_eq("hold_busy", busy, 0);
        end
        enable = 1'b1; tick();
        expect_stream(16'h00E4, 4, 4, 1'b0, -1, -1, -1, 1'b1);
        tick();

        // period change mid-byte takes effect on the next byte only
        seq6 = 8'h1E;
        offer(8'hB4); tick();
        s_valid = 1'b0; tick();
        for (int k = 0; k < 16; k++) begin
            if (k == 2) sym_period = 16'd8;
            check_eq("chg_sel", sel, seq6[2*(k/4) +: 2]);
            check_eq("chg_busy", busy, 1);
            tick();
        end
        check_eq("chg_underrun", underrun, 1);
        check_eq("chg_busy_end", busy, 0);
        offer(8'hE4); tick();
        s_valid = 1'b0; tick();
        expect_stream(16'h001B, 4, 8, 1'b0, -1, -1, -1, 1'b1);
        tick();

        // asynchronous reset mid-symbol drops the active and the buffered byte
        sym_period = 16'd4;
        offer(8'hB4); tick();
        offer(8'h1B); tick();
        tick(); tick();
        check_eq("pre_rst_ready", s_ready, 0);
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("arst_sel", sel, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_ready", s_ready, 1);
        check_eq("arst_strobe", sym_strobe, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("post_rst_busy", busy, 0);
            check_eq("post_rst_sel", sel, 0);
            check_eq("post_rst_ready", s_ready, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fsk_symbol_serializer.md
# fsk_symbol_serializer

Byte-to-symbol serializer placed directly upstream of the FSK frequency mapper. It accepts data bytes over a valid/ready handshake and splits each byte into four 2-bit symbols. It holds each symbol on `sel` for a programmable number of clock cycles, and `sel` drives the mapper's symbol-select input. A one-byte holding buffer lets the next byte follow the current one with no gap between symbols.

## Interface
- `MSB_FIRST`, default 1: 1 sends bits [7:6],[5:4],[3:2],[1:0] in that order; 0 sends [1:0],[3:2],[5:4],[7:6].
- `IDLE_SYM`, default 2'b00: value driven on `sel` whenever no byte is being transmitted.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  allows a new byte to start transmitting.
- `sym_period`  in  16  clocks per symbol, unsigned; values 0 and 1 both mean 1 clock.
- `s_data`  in  8  input byte.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  holding buffer is empty; a byte is accepted on any edge where `s_valid && s_ready`.
- `sel`  out  2  current symbol, registered; connects to the mapper's `sel`.
- `sym_strobe`  out  1  one-cycle pulse in the first cycle each new symbol appears on `sel`.
- `busy`  out  1  high while in SEND.
- `underrun`  out  1  one-cycle pulse when SEND ends because the buffer is empty.

## Operation
- Storage:
  - `next_reg[7:0]` with flag `next_full`.
  - Shift register `cur_reg[7:0]`.
  - Symbol index `sym_idx[1:0]`.
  - Period counter `cnt[15:0]`.
  - Latched period `per_q[15:0]`.
- `s_ready = !next_full`, registered; there is no combinational path from `s_valid`. On a handshake, `next_reg <= s_data` and `next_full <= 1`.
- `enable` gates only the start of a new byte. Dropping `enable` mid-byte lets the current byte finish all 4 symbols, then the block goes to IDLE. `s_ready` does not depend on `enable`.
- State IDLE:
  - `sel=IDLE_SYM`, `busy=0`.
  - If `enable && next_full`:
    - Load `cur_reg <= next_reg` and clear `next_full`.
    - Set `sym_idx=0`, `cnt=0`, `per_q=max(sym_period,1)`.
    - Drive `sel` with the first symbol and pulse `sym_strobe`.
    - Go to SEND.
- State SEND:
  - `cnt` increments each clock.
  - When `cnt == per_q-1`, the symbol ends: `cnt <= 0`.
    - If `sym_idx < 3`: increment `sym_idx`, present the next symbol, pulse `sym_strobe`.
    - If `sym_idx == 3` and `enable && next_full`: load the next byte exactly as in IDLE (including re-latching `per_q` and pulsing `sym_strobe`); stay in SEND with no idle cycle.
    - If `sym_idx == 3` and `!next_full`: go to IDLE, set `sel <= IDLE_SYM`, pulse `underrun`.
    - If `sym_idx == 3` and `next_full` but `!enable`: go to IDLE with no `underrun` pulse.
- Period rule: `per_q` is latched only at byte start. Changing `sym_period` mid-byte takes effect on the next byte.
- Handshake concurrent with a transfer: not possible, because `s_ready` is 0 whenever `next_full` is set. The buffer reopens the cycle after the transfer.
- Reset (asynchronous, any state): IDLE, `next_full=0`, `sel=IDLE_SYM`, `sym_strobe=0`, `busy=0`, `underrun=0`, `s_ready=1`, all counters 0. A byte in progress or buffered at reset is discarded.

## Timing
- Handshake on edge E with IDLE and `enable=1`:
  - `next_full=1` after E.
  - At edge E+1 the byte is loaded; `sel`, `sym_strobe` and `busy` are valid after E+1.
- Each symbol holds for exactly `per_q` clocks; one byte occupies `4*per_q` clocks.
- Back-to-back bytes produce a continuous symbol stream, with `sym_strobe` every `per_q` clocks, provided the next byte is accepted before the last symbol of the current byte ends.
- `underrun` and the return of `sel` to `IDLE_SYM` occur on the same edge, `4*per_q` clocks after the byte was loaded.
- `sel` is fully registered and glitch-free; the mapper samples it on the same `clk`.

## Test plan
- Single byte, MSB-first:
  - Stimulus: `sym_period=4`, `enable=1`, send 0xB4.
  - Response: `sel` = 2,3,1,0, each held 4 cycles; four `sym_strobe` pulses 4 cycles apart; `underrun` pulse; `sel` returns to 0; `busy` high for exactly 16 cycles.
- Back-to-back:
  - Stimulus: `sym_period=3`, send 0xB4 then 0x1B immediately.
  - Response: `sel` = 2,3,1,0,0,1,2,3 with no gap; a single `underrun` after the 24th symbol cycle; `s_ready` is low while 0x1B is buffered.
- Minimum period:
  - Stimulus: `sym_period=0`, then repeat with `sym_period=1`, send 0xE4.
  - Response: `sel` = 3,2,1,0 on consecutive cycles; `sym_strobe` high 4 consecutive cycles.
- LSB-first:
  - Stimulus: `MSB_FIRST=0`, `sym_period=2`, send 0xB4.
  - Response: `sel` = 0,1,3,2.
- `enable` drop:
  - Stimulus: send 0xB4 and 0x1B; drop `enable` during the 2nd symbol of 0xB4.
  - Response: 0xB4 completes; IDLE with no `underrun`; 0x1B stays buffered (`s_ready=0`) until `enable` rises, after which it is sent.
- Mid-operation change and reset:
  - Stimulus: change `sym_period` 4→8 mid-byte.
  - Response: the current byte keeps 4-cycle symbols.
  - Stimulus: assert `rst` mid-symbol.
  - Response: `sel=IDLE_SYM` and `busy=0` immediately (asynchronous); `s_ready=1`; the buffered byte is lost.
